// File: rtl/solver_stream_adapter.sv
// Streams multi_solver's banked iteration memory to an Avalon-ST video sink in raster order.
// Reads are credit-limited so that every returning pixel has a reserved slot in the output FIFO.
module solver_stream_adapter #(
  parameter int NUM_SOLVERS = 10,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic [5:0]        rd_solver_id,
  output logic [18:0]       rd_addr,
  input  logic signed [3:0] rd_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  output logic [7:0]        out_data,
  output logic [15:0]       frame_count
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int PW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } entry_t;

  logic [PW-1:0]         pix_q, pix_d;
  logic [5:0]            bank_q, bank_d;
  logic [18:0]           addr_q, addr_d;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0] tag_sop_q, tag_sop_d;
  logic [RD_LATENCY-1:0] tag_eop_q, tag_eop_d;
  entry_t                fifo_q [FIFO_DEPTH];
  entry_t                fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic [CNT_W-1:0] inflight;
  logic [CNT_W:0]   credit_used;
  logic             issue;
  logic             push;
  logic             pop;
  logic             last_pix;
  entry_t           head;
  entry_t           push_entry;

  // Credits: a slot is owned by every read in the tag pipe as well as every stored pixel.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(tag_vld_q[i]);
    end
    credit_used = {1'b0, count_q} + {1'b0, inflight};
    issue       = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
    last_pix    = pix_q == PW'(TOTAL - 1);
  end

  always_comb begin
    pix_d  = pix_q;
    bank_d = bank_q;
    addr_d = addr_q;
    if (issue) begin
      if (last_pix) begin
        pix_d  = '0;
        bank_d = '0;
        addr_d = '0;
      end else begin
        pix_d = pix_q + PW'(1);
        if (bank_q == 6'(NUM_SOLVERS - 1)) begin
          bank_d = '0;
          addr_d = addr_q + 19'd1;
        end else begin
          bank_d = bank_q + 6'd1;
        end
      end
    end
  end

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_sop_d    = tag_sop_q;
    tag_eop_d    = tag_eop_q;
    tag_vld_d[0] = issue;
    tag_sop_d[0] = issue && (pix_q == '0);
    tag_eop_d[0] = issue && last_pix;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_sop_d[i] = tag_sop_q[i-1];
      tag_eop_d[i] = tag_eop_q[i-1];
    end
  end

  // Negative iteration values are points inside the set and render black.
  always_comb begin
    push            = tag_vld_q[RD_LATENCY-1];
    push_entry.sop  = tag_sop_q[RD_LATENCY-1];
    push_entry.eop  = tag_eop_q[RD_LATENCY-1];
    push_entry.data = rd_data[3] ? 8'h00 : {rd_data[3:0], rd_data[3:0]};
    head            = fifo_q[rd_ptr_q];
    pop             = (count_q != '0) && out_ready;
  end

  always_comb begin
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    frame_count_d = frame_count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_entry;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (head.eop) begin
        frame_count_d = frame_count_q + 16'd1;
      end
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pix_q         <= '0;
      bank_q        <= '0;
      addr_q        <= '0;
      tag_vld_q     <= '0;
      tag_sop_q     <= '0;
      tag_eop_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      pix_q         <= pix_d;
      bank_q        <= bank_d;
      addr_q        <= addr_d;
      tag_vld_q     <= tag_vld_d;
      tag_sop_q     <= tag_sop_d;
      tag_eop_q     <= tag_eop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_count_q <= frame_count_d;
      fifo_q        <= fifo_d;
    end
  end

  // The credit rule makes this unreachable; firing means the credit accounting is broken.
  fifo_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));

  assign rd_solver_id      = bank_q;
  assign rd_addr           = addr_q;
  assign out_valid         = count_q != '0;
  assign out_startofpacket = out_valid && head.sop;
  assign out_endofpacket   = out_valid && head.eop;
  assign out_data          = out_valid ? head.data : 8'h00;
  assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_solver_stream_adapter.sv
// Scoreboard bench for solver_stream_adapter: a reference model predicts the pixel stream,
// and a negedge monitor compares every presented beat against the queue head.
module tb_solver_stream_adapter;

  localparam int NS    = 10;
  localparam int W     = 40;
  localparam int H     = 30;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TOTAL = W * H;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [5:0]        rd_solver_id;
  logic [18:0]       rd_addr;
  logic signed [3:0] rd_data;
  logic              out_ready;
  logic              out_valid;
  logic              out_startofpacket;
  logic              out_endofpacket;
  logic [7:0]        out_data;
  logic [15:0]       frame_count;

  int checks = 0;
  int failures = 0;
  int data_mode = 0;
  int ready_mode = 0;
  int rnd_tab [64];
  beat_t sb_q [$];

  int issued = 0;
  int popped = 0;
  int max_out = 0;
  int bubbles = 0;
  logic seen = 1'b0;
  logic [15:0] exp_fc = 16'd0;
  logic [24:0] prev_rd = '0;
  logic [3:0] s1 = 4'd0;
  logic [3:0] s2 = 4'd0;

  solver_stream_adapter #(
    .NUM_SOLVERS(NS), .WIDTH(W), .HEIGHT(H), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rd_solver_id(rd_solver_id),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .out_data(out_data),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  // Signed iteration value stored by the solver for a given bank/word, range -8..7.
  function automatic int solver_value(input int bank, input int addr);
    int p;
    int a;
    p = addr * NS + bank;
    case (data_mode)
      0: begin
        a = addr % 16;
        return (a >= 8) ? a - 16 : a;
      end
      1: begin
        case (p % 4)
          0: return -1;
          1: return 0;
          2: return 5;
          default: return 7;
        endcase
      end
      default: return rnd_tab[p % 64];
    endcase
  endfunction

  function automatic beat_t model_beat(input int k);
    beat_t b;
    int p;
    int v;
    p = k % TOTAL;
    v = solver_value(p % NS, p / NS);
    b.data = (v < 0) ? 8'h00 : 8'(v * 17);
    b.sop  = (p == 0);
    b.eop  = (p == TOTAL - 1);
    return b;
  endfunction

  // Solver memory: two-cycle registered read.
  always @(posedge clock) begin
    s1 <= 4'(solver_value(int'(rd_solver_id), int'(rd_addr)));
    s2 <= s1;
  end
  assign rd_data = $signed(s2);

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic checkOutput();
    beat_t got;
    beat_t exp;
    if (sb_q.size() != 0) begin
      checks++;
      if (frame_count !== exp_fc) begin
        failures++;
        $display("[TB] FAIL frame_count: got %0d expected %0d", frame_count, exp_fc);
      end
      if (out_valid) begin
        seen     = 1'b1;
        got.sop  = out_startofpacket;
        got.eop  = out_endofpacket;
        got.data = out_data;
        exp      = sb_q[0];
        checks++;
        if (got !== exp) begin
          failures++;
          $display("[TB] FAIL beat sop/eop/data: got %b/%b/%h expected %b/%b/%h",
                   got.sop, got.eop, got.data, exp.sop, exp.eop, exp.data);
        end
        if (out_ready) begin
          void'(sb_q.pop_front());
          if (exp.eop) exp_fc = exp_fc + 16'd1;
        end
      end else if (ready_mode == 0 && seen) begin
        bubbles++;
      end
    end
    if (out_valid && out_ready) popped++;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      issued  = 0;
      popped  = 0;
      max_out = 0;
      bubbles = 0;
      seen    = 1'b0;
      exp_fc  = 16'd0;
      prev_rd = '0;
    end else begin
      if ({rd_solver_id, rd_addr} != prev_rd) begin
        issued++;
        prev_rd = {rd_solver_id, rd_addr};
      end
      if (issued - popped > max_out) max_out = issued - popped;
      checkOutput();
    end
  end

  task automatic syncDrive();
    @(posedge clock);
    #2;
  endtask

  task automatic pushExpected(input int n);
    for (int k = 0; k < n; k++) sb_q.push_back(model_beat(k));
  endtask

  task automatic waitDrain(input int budget);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < budget) begin
      @(negedge clock);
      c++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d beats still expected after %0d cycles, required 0", sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  task automatic applyStimulus(input int dmode, input int rmode, input int nbeats, input int stall);
    int lat;
    syncDrive();
    reset = 1'b1;
    sb_q.delete();
    data_mode  = dmode;
    ready_mode = (stall > 0) ? 2 : rmode;
    repeat (3) syncDrive();
    checks++;
    if (out_valid !== 1'b0 || frame_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset state: valid=%b frame_count=%0d, required 0/0", out_valid, frame_count);
    end
    pushExpected(nbeats);
    reset = 1'b0;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (out_valid) break;
      lat++;
    end
    checks++;
    if (lat != LAT + 1) begin
      failures++;
      $display("[TB] FAIL first valid latency: got %0d cycles, required %0d", lat, LAT + 1);
    end
    if (stall > 0) begin
      repeat (stall) @(negedge clock);
      checks++;
      if (issued != DEPTH) begin
        failures++;
        $display("[TB] FAIL reads issued while stalled: got %0d, required %0d", issued, DEPTH);
      end
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL valid while stalled: got %b, required 1", out_valid);
      end
      ready_mode = rmode;
    end
    waitDrain(nbeats * 4 + 200);
    checks++;
    if (max_out > DEPTH) begin
      failures++;
      $display("[TB] FAIL outstanding reads: got %0d, required <= %0d", max_out, DEPTH);
    end
    if (rmode == 0 && stall == 0) begin
      checks++;
      if (bubbles != 0) begin
        failures++;
        $display("[TB] FAIL bubbles with ready high: got %0d, required 0", bubbles);
      end
    end
  endtask

  task automatic midFrameReset();
    int c;
    syncDrive();
    reset = 1'b1;
    sb_q.delete();
    data_mode  = 0;
    ready_mode = 0;
    repeat (3) syncDrive();
    pushExpected(1100);
    reset = 1'b0;
    c = 0;
    while (popped < 1000 && c < 5000) begin
      @(negedge clock);
      c++;
    end
    checks++;
    if (popped < 1000) begin
      failures++;
      $display("[TB] FAIL reach pixel 1000: got %0d beats, required 1000", popped);
    end
    syncDrive();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL valid after mid-frame reset: got %b, required 0", out_valid);
    end
    checks++;
    if (rd_solver_id !== 6'd0 || rd_addr !== 19'd0 || frame_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL counters after reset: bank=%0d addr=%0d fc=%0d, required 0/0/0",
               rd_solver_id, rd_addr, frame_count);
    end
    sb_q.delete();
    applyStimulus(0, 0, 60, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rnd_tab[i] = int'($urandom_range(0, 15)) - 8;
    $display("[TB] start");
    applyStimulus(0, 0, 60, 0);
    applyStimulus(0, 0, TOTAL + 1, 0);
    applyStimulus(0, 1, 10000, 0);
    applyStimulus(0, 0, 12, 20);
    applyStimulus(1, 0, 40, 0);
    midFrameReset();
    applyStimulus(2, 1, 3000, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
